// File: rtl/pc_ir_fetch_unit.sv
// pc_ir_fetch_unit: PC/IR owner with a single-word imem prefetch buffer for the multicycle controller.
// Define FETCH_BYPASS_EN to load the IR straight from imem_rdata when a waiting IRWrite meets a fresh ack.
module pc_ir_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCWrite,
   input  logic              PCWriteCond,
   input  logic [1:0]        PCSource,
   input  logic              IRWrite,
   input  logic              zero,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [ADDR_W-1:0] alu_out,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [5:0]        opcode,
   output logic              fetch_stall
);
   typedef enum logic [2:0] {START, REQ, STALE, RETRY, VALID} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] addr_q, pc_nxt;
   logic [DATA_W-1:0] fetch_buf;
   logic ir_pending, pc_we, buf_valid, want, byp, consume, load_ir;
   assign pc_we     = PCWrite | (PCWriteCond & zero);
   assign buf_valid = state == VALID;
   assign want      = IRWrite | ir_pending;
   assign consume   = want & buf_valid;
`ifdef FETCH_BYPASS_EN
   assign byp = want & (state == REQ) & imem_ack & ~pc_we;
`else
   assign byp = 1'b0;
`endif
   assign load_ir     = consume | byp;
   assign fetch_stall = (ir_pending | (IRWrite & ~buf_valid)) & ~byp;
   assign opcode      = ir[DATA_W-1:DATA_W-6];
   assign pc_nxt = PCSource == 2'b00 ? alu_result :
                   PCSource == 2'b01 ? alu_out :
                   PCSource == 2'b10 ? {pc[ADDR_W-1:26], ir[25:0]} : RESET_VEC;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= START;
         pc         <= RESET_VEC;
         ir         <= '0;
         fetch_buf  <= '0;
         addr_q     <= RESET_VEC;
         ir_pending <= 1'b0;
      end else begin
         state      <= state_nxt;
         ir_pending <= want & ~load_ir & ~pc_we;
         if (pc_we) pc <= pc_nxt;
         if (state == REQ) addr_q <= pc;
         if (state == REQ && imem_ack && !pc_we) fetch_buf <= imem_rdata;
         if (load_ir) ir <= byp ? imem_rdata : fetch_buf;
      end
   end
   // a redirect while waiting keeps the old request alive (STALE) since requests are never withdrawn
   always_comb begin
      state_nxt = state;
      case (state)
         START:   state_nxt = REQ;
         REQ:     state_nxt = imem_ack ? (pc_we ? RETRY : (byp ? REQ : VALID)) : (pc_we ? STALE : REQ);
         STALE:   state_nxt = imem_ack ? REQ : STALE;
         RETRY:   state_nxt = REQ;
         VALID:   state_nxt = (pc_we | consume) ? REQ : VALID;
         default: state_nxt = START;
      endcase
   end
   always_comb begin
      imem_req  = (state == REQ) | (state == STALE);
      imem_addr = state == STALE ? addr_q : pc;
   end
endmodule

// File: tb/tb_pc_ir_fetch_unit.sv
// tb_pc_ir_fetch_unit: directed vectors for pc_ir_fetch_unit, both with and without FETCH_BYPASS_EN.
module tb_pc_ir_fetch_unit;
   logic        clk = 0, reset = 0;
   logic        PCWrite, PCWriteCond, IRWrite, zero, imem_ack;
   logic [1:0]  PCSource;
   logic [31:0] alu_result, alu_out, imem_rdata;
   logic        imem_req, fetch_stall;
   logic [31:0] imem_addr, pc, ir;
   logic [5:0]  opcode;
   int n_vec = 0, n_err = 0;

   pc_ir_fetch_unit dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .IRWrite(IRWrite), .zero(zero), .alu_result(alu_result),
      .alu_out(alu_out), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .opcode(opcode), .fetch_stall(fetch_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      PCWrite = 0; PCWriteCond = 0; IRWrite = 0; zero = 0; imem_ack = 0;
      PCSource = 2'b00; alu_result = '0; alu_out = '0; imem_rdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   initial begin
      idle();
      #2;
      chk("rst_pc", pc, 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_stall", {31'b0, fetch_stall}, 32'd0);
      step();
      step();
      reset = 1;
      step();
      chk("start_req", {31'b0, imem_req}, 32'd1);
      chk("start_addr", imem_addr, 32'h0);
      step();
      chk("req_held", {31'b0, imem_req}, 32'd1);
      imem_ack = 1; imem_rdata = 32'h0800_0005;
      step();
      chk("valid_req", {31'b0, imem_req}, 32'd0);
      chk("valid_ir", ir, 32'h0);
      chk("valid_op", {26'b0, opcode}, 32'h0);
      // IF entry: IR gets old-pc word, pc advances, new fetch next cycle
      IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'h1;
      #1;
      chk("if_stall", {31'b0, fetch_stall}, 32'd0);
      step();
      chk("if_ir", ir, 32'h0800_0005);
      chk("if_op", {26'b0, opcode}, 32'h2);
      chk("if_pc", pc, 32'h1);
      chk("if_req", {31'b0, imem_req}, 32'd1);
      chk("if_addr", imem_addr, 32'h1);
      imem_ack = 1; imem_rdata = 32'h0800_0123;
      step();
      chk("a1_req", {31'b0, imem_req}, 32'd0);
      IRWrite = 1;
      step();
      chk("reif_ir", ir, 32'h0800_0123);
      chk("reif_req", {31'b0, imem_req}, 32'd1);
      chk("reif_addr", imem_addr, 32'h1);
      PCWrite = 1; PCSource = 2'b10;
      step();
      chk("jmp_pc", pc, 32'h0000_0123);
      chk("jmp_stale_req", {31'b0, imem_req}, 32'd1);
      chk("jmp_stale_addr", imem_addr, 32'h1);
      imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
      step();
      chk("jmp_req_addr", imem_addr, 32'h0000_0123);
      chk("jmp_ir_kept", ir, 32'h0800_0123);
      imem_ack = 1; imem_rdata = 32'hFC00_0000;
      step();
      chk("jmp_valid_req", {31'b0, imem_req}, 32'd0);
      PCWriteCond = 1; zero = 1; PCSource = 2'b01; alu_out = 32'h40;
      step();
      chk("br_pc", pc, 32'h40);
      chk("br_addr", imem_addr, 32'h40);
      chk("br_req", {31'b0, imem_req}, 32'd1);
      imem_ack = 1; imem_rdata = 32'h1111_0000;
      step();
      PCWriteCond = 1; zero = 0; PCSource = 2'b01; alu_out = 32'h99;
      step();
      chk("nbr_pc", pc, 32'h40);
      chk("nbr_req", {31'b0, imem_req}, 32'd0);
      imem_ack = 1; imem_rdata = 32'h0000_0BAD;
      step();
      chk("stray_ack_req", {31'b0, imem_req}, 32'd0);
      IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'h1;
      step();
      chk("if2_ir", ir, 32'h1111_0000);
      chk("if2_op", {26'b0, opcode}, 32'h4);
      chk("if2_addr", imem_addr, 32'h1);
      step();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h1);
      // redirect while the request for address 1 is still outstanding
      PCWrite = 1; PCSource = 2'b00; alu_result = 32'h80;
      step();
      chk("redir_pc", pc, 32'h80);
      chk("redir_addr", imem_addr, 32'h1);
      IRWrite = 1;
      #1;
      chk("irw_stall", {31'b0, fetch_stall}, 32'd1);
      step();
      chk("pend_stall", {31'b0, fetch_stall}, 32'd1);
      chk("pend_ir", ir, 32'h1111_0000);
      imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("drop_addr", imem_addr, 32'h80);
      chk("drop_req", {31'b0, imem_req}, 32'd1);
      chk("drop_stall", {31'b0, fetch_stall}, 32'd1);
      chk("drop_ir", ir, 32'h1111_0000);
      imem_ack = 1; imem_rdata = 32'h1234_5678;
      #1;
`ifdef FETCH_BYPASS_EN
      chk("byp_stall", {31'b0, fetch_stall}, 32'd0);
      step();
`else
      chk("ack_stall", {31'b0, fetch_stall}, 32'd1);
      step();
      chk("buf_ir", ir, 32'h1111_0000);
      chk("buf_stall", {31'b0, fetch_stall}, 32'd1);
      chk("buf_req", {31'b0, imem_req}, 32'd0);
      step();
`endif
      chk("load_ir", ir, 32'h1234_5678);
      chk("load_stall", {31'b0, fetch_stall}, 32'd0);
      chk("refetch_req", {31'b0, imem_req}, 32'd1);
      chk("refetch_addr", imem_addr, 32'h80);
      #2;
      reset = 0;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_req", {31'b0, imem_req}, 32'd0);
      chk("arst_ir", ir, 32'h0);
      chk("arst_stall", {31'b0, fetch_stall}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
